// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension pipeline: extension modes and buffer occupancy states.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_SIGN   = 2'd0,
        IMM_ZERO   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } imm_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension (SIGN / ZERO / UPPER / BRANCH).
// Mode 3 is a shifted sign extension only when IMM_EXTEND_BRANCH_EN is defined; otherwise it behaves as SIGN.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] result_o
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;

    // Size casts handle IN_W == OUT_W without a zero-width replication.
    assign sext = OUT_W'($signed(imm_i));
    assign zext = OUT_W'(imm_i);

    always_comb begin
        result_o = sext;
        case (imm_mode_t'(mode_i))
            IMM_SIGN:   result_o = sext;
            IMM_ZERO:   result_o = zext;
            IMM_UPPER:  result_o = zext << (OUT_W - IN_W);
`ifdef IMM_EXTEND_BRANCH_EN
            IMM_BRANCH: result_o = sext << 2;
`else
            IMM_BRANCH: result_o = sext;
`endif
            default:    result_o = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender feeding a 2-entry skid buffer with valid/ready on both sides.
// Optional feature macro: IMM_EXTEND_BRANCH_EN (enables the BRANCH shift for mode 3).
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    imm_state_t       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] head_data_q, head_data_d;
    logic [TAG_W-1:0] head_tag_q, head_tag_d;
    logic [OUT_W-1:0] tail_data_q, tail_data_d;
    logic [TAG_W-1:0] tail_tag_q, tail_tag_d;
    logic [OUT_W-1:0] ext_data;
    logic             accept;
    logic             retire;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i    (in_imm),
        .mode_i   (in_mode),
        .result_o (ext_data)
    );

    assign accept = in_valid && in_ready_q;
    assign retire = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_tag_d  = head_tag_q;
        tail_data_d = tail_data_q;
        tail_tag_d  = tail_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_data_d = ext_data;
                    head_tag_d  = in_tag;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && retire) begin
                    head_data_d = ext_data;
                    head_tag_d  = in_tag;
                end else if (accept) begin
                    tail_data_d = ext_data;
                    tail_tag_d  = in_tag;
                    state_d     = ST_FULL;
                end else if (retire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (retire) begin
                    head_data_d = tail_data_q;
                    head_tag_d  = tail_tag_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Handshake flags are registered from the next state so no input reaches an output combinationally.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_data_q <= '0;
            head_tag_q  <= '0;
            tail_data_q <= '0;
            tail_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_data_q <= head_data_d;
            head_tag_q  <= head_tag_d;
            tail_data_q <= tail_data_d;
            tail_tag_q  <= tail_tag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_data_q;
    assign out_tag   = head_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe; inputs change and outputs are sampled on the falling edge.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int unsigned n_cmp;
    int unsigned n_err;

    imm_extend_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .TAG_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single beat through an empty buffer: visible one edge after accept, gone one edge later.
    task automatic send_one(input string name, input logic [1:0] mode, input logic [15:0] imm,
                            input logic [4:0] tag, input logic [31:0] exp);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_imm    = imm;
        in_tag    = tag;
        out_ready = 1'b1;
        next_neg();
        in_valid = 1'b0;
        check_val({name, "_valid"}, 32'(out_valid), 32'd1);
        check_val({name, "_data"}, out_data, exp);
        check_val({name, "_tag"}, 32'(out_tag), 32'(tag));
        next_neg();
        check_val({name, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] branch_exp;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = 2'd0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", out_data, 32'h0);
        check_val("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send_one("sign_neg", 2'd0, 16'h8000, 5'd3, 32'hFFFF_8000);
        send_one("zero", 2'd1, 16'h8000, 5'd4, 32'h0000_8000);
        send_one("upper", 2'd2, 16'h1234, 5'd5, 32'h1234_0000);
        send_one("sign_pos", 2'd0, 16'h7FFF, 5'd6, 32'h0000_7FFF);
`ifdef IMM_EXTEND_BRANCH_EN
        branch_exp = 32'hFFFF_FFFC;
`else
        branch_exp = 32'hFFFF_FFFF;
`endif
        send_one("branch", 2'd3, 16'hFFFF, 5'd7, branch_exp);
        send_one("upper_neg", 2'd2, 16'hFFFF, 5'd8, 32'hFFFF_0000);

        // Backpressure: ZERO mode with imm == tag so data and tag cross-check.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_imm    = 16'd1;
        in_tag    = 5'd1;
        next_neg();
        check_val("bp_ready_after1", 32'(in_ready), 32'd1);
        check_val("bp_head1", 32'(out_tag), 32'd1);
        in_imm = 16'd2;
        in_tag = 5'd2;
        next_neg();
        check_val("bp_ready_after2", 32'(in_ready), 32'd0);
        check_val("bp_valid_full", 32'(out_valid), 32'd1);
        in_imm = 16'd3;
        in_tag = 5'd3;
        next_neg();
        check_val("bp_still_full", 32'(in_ready), 32'd0);
        check_val("bp_hold_tag", 32'(out_tag), 32'd1);
        check_val("bp_hold_data", out_data, 32'd1);
        out_ready = 1'b1;
        next_neg();
        check_val("bp_deliver2_tag", 32'(out_tag), 32'd2);
        check_val("bp_deliver2_data", out_data, 32'd2);
        check_val("bp_ready_reopen", 32'(in_ready), 32'd1);
        next_neg();
        in_valid = 1'b0;
        check_val("bp_deliver3_tag", 32'(out_tag), 32'd3);
        check_val("bp_deliver3_data", out_data, 32'd3);
        next_neg();
        check_val("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: accept and retire every edge while in ONE.
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_imm    = 16'd10;
        in_tag    = 5'd10;
        out_ready = 1'b1;
        next_neg();
        for (int i = 1; i <= 8; i++) begin
            check_val("stream_valid", 32'(out_valid), 32'd1);
            check_val("stream_ready", 32'(in_ready), 32'd1);
            check_val("stream_tag", 32'(out_tag), 32'(10 + i - 1));
            in_imm = 16'(10 + i);
            in_tag = 5'(10 + i);
            next_neg();
        end
        in_valid = 1'b0;
        check_val("stream_last_tag", 32'(out_tag), 32'd18);
        check_val("stream_last_data", out_data, 32'd18);
        next_neg();
        check_val("stream_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_imm    = 16'h0055;
        in_tag    = 5'd20;
        next_neg();
        in_tag = 5'd21;
        next_neg();
        in_valid = 1'b0;
        check_val("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 32'(out_valid), 32'd0);
        check_val("arst_in_ready", 32'(in_ready), 32'd1);
        check_val("arst_out_data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_one("post_rst", 2'd0, 16'h8000, 5'd3, 32'hFFFF_8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
